// File: rtl/bootloader_top.sv
// UART-to-SPI-flash boot bridge: break + 0xBC unlocks, then length-prefixed SPI transfers and a warmboot request.
// SPI bytes are paced by UART bytes (write) or by UART TX availability (read); no buffering beyond one byte.
module bootloader_top #(
   parameter int CLK_FREQ      = 12000000,
   parameter int UART_BAUDRATE = 115200,
   parameter int SPI_CLK_DIV   = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic uart0_rx,
   output logic uart0_tx,
   input  logic spi_si,
   output logic spi_so,
   output logic spi_sck,
   output logic spi_ss_n,
   inout  wire  i2c_sda,
   inout  wire  i2c_scl,
   output logic boot
);

   localparam int BIT = CLK_FREQ / UART_BAUDRATE;
   localparam int BRK = 16 * BIT;
   localparam int CW  = $clog2(BRK + 1);
   localparam int DW  = (SPI_CLK_DIV > 1) ? $clog2(SPI_CLK_DIV) : 1;
   localparam int EW  = $clog2(2 * SPI_CLK_DIV);

   localparam logic [CW-1:0] BIT_M1  = CW'(BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(BIT / 2 - 1);
   localparam logic [CW-1:0] BRK_C   = CW'(BRK);
   localparam logic [CW-1:0] BRK_M1  = CW'(BRK - 1);
   localparam logic [DW-1:0] DIV_M1  = DW'(SPI_CLK_DIV - 1);
   localparam logic [EW-1:0] END_M1  = EW'(2 * SPI_CLK_DIV - 1);

   typedef enum logic [3:0] {
      S_LOCKED, S_ARMED, S_IDLE, S_LEN0, S_LEN1, S_LEN2, S_LEN3,
      S_TX, S_RX_SPI, S_RX_WAIT, S_RX_SEND, S_END, S_BOOT
   } state_t;

   state_t state, state_nxt;

   logic [1:0]    rx_sync;
   logic          rxs;
   logic          rx_busy, rx_hold, byte_vld, brk_vld;
   logic [CW-1:0] rx_cnt, brk_cnt;
   logic [3:0]    rx_idx;
   logic [7:0]    rx_sh;

   logic [9:0]    tx_sh;
   logic          tx_busy, tx_go;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_idx;

   logic          spi_busy, spi_done, spi_go, spi_abort;
   logic [7:0]    spi_byte, spi_mosi_sh, spi_miso_sh;
   logic [3:0]    spi_ph;
   logic [DW-1:0] spi_div;

   logic [15:0]   txlen, rxlen;
   logic [7:0]    len_lo;
   logic [EW-1:0] end_cnt;

   assign i2c_sda = 1'bz;
   assign i2c_scl = 1'bz;

   assign rxs = rx_sync[1];

   always_ff @(posedge clk) begin
      if (!rst_n) rx_sync <= 2'b11;
      else        rx_sync <= {rx_sync[0], uart0_rx};
   end

   // After a break or a framing error the receiver waits for a high line before looking for a start bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_busy  <= 1'b0;
         rx_hold  <= 1'b1;
         byte_vld <= 1'b0;
         brk_vld  <= 1'b0;
         rx_cnt   <= '0;
         brk_cnt  <= '0;
         rx_idx   <= '0;
         rx_sh    <= '0;
      end else begin
         byte_vld <= 1'b0;
         brk_vld  <= 1'b0;
         if (rxs)                  brk_cnt <= '0;
         else if (brk_cnt != BRK_C) brk_cnt <= brk_cnt + 1'b1;

         if (!rxs && brk_cnt == BRK_M1) begin
            brk_vld <= 1'b1;
            rx_busy <= 1'b0;
            rx_hold <= 1'b1;
         end else if (!rx_busy) begin
            if (rx_hold) begin
               if (rxs) rx_hold <= 1'b0;
            end else if (!rxs) begin
               rx_busy <= 1'b1;
               rx_cnt  <= '0;
               rx_idx  <= '0;
            end
         end else if (rx_cnt == ((rx_idx == 4'd0) ? HALF_M1 : BIT_M1)) begin
            rx_cnt <= '0;
            rx_idx <= rx_idx + 4'd1;
            if (rx_idx == 4'd0) begin
               if (rxs) rx_busy <= 1'b0;
            end else if (rx_idx == 4'd9) begin
               rx_busy <= 1'b0;
               if (rxs) byte_vld <= 1'b1;
               else     rx_hold  <= 1'b1;
            end else begin
               rx_sh <= {rxs, rx_sh[7:1]};
            end
         end else begin
            rx_cnt <= rx_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_sh   <= '1;
         tx_busy <= 1'b0;
         tx_cnt  <= '0;
         tx_idx  <= '0;
      end else if (!tx_busy) begin
         if (tx_go) begin
            tx_sh   <= {1'b1, spi_miso_sh, 1'b0};
            tx_busy <= 1'b1;
            tx_cnt  <= '0;
            tx_idx  <= '0;
         end
      end else if (tx_cnt == BIT_M1) begin
         tx_cnt <= '0;
         tx_sh  <= {1'b1, tx_sh[9:1]};
         if (tx_idx == 4'd9) tx_busy <= 1'b0;
         else                tx_idx  <= tx_idx + 4'd1;
      end else begin
         tx_cnt <= tx_cnt + 1'b1;
      end
   end

   assign uart0_tx = tx_sh[0];

   // Even phases raise SCK and sample MISO, odd phases lower SCK and present the next MOSI bit.
   always_ff @(posedge clk) begin
      if (!rst_n || spi_abort) begin
         spi_busy    <= 1'b0;
         spi_done    <= 1'b0;
         spi_sck     <= 1'b0;
         spi_so      <= 1'b0;
         spi_ph      <= '0;
         spi_div     <= '0;
         spi_mosi_sh <= '0;
         spi_miso_sh <= '0;
      end else begin
         spi_done <= 1'b0;
         if (!spi_busy) begin
            if (spi_go) begin
               spi_busy    <= 1'b1;
               spi_so      <= spi_byte[7];
               spi_mosi_sh <= {spi_byte[6:0], 1'b0};
               spi_ph      <= '0;
               spi_div     <= '0;
            end
         end else if (spi_div == DIV_M1) begin
            spi_div <= '0;
            spi_ph  <= spi_ph + 4'd1;
            if (!spi_ph[0]) begin
               spi_sck     <= 1'b1;
               spi_miso_sh <= {spi_miso_sh[6:0], spi_si};
            end else begin
               spi_sck <= 1'b0;
               if (spi_ph == 4'd15) begin
                  spi_busy <= 1'b0;
                  spi_done <= 1'b1;
                  spi_so   <= 1'b0;
               end else begin
                  spi_so      <= spi_mosi_sh[7];
                  spi_mosi_sh <= {spi_mosi_sh[6:0], 1'b0};
               end
            end
         end else begin
            spi_div <= spi_div + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_LOCKED;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      spi_go    = 1'b0;
      spi_byte  = rx_sh;
      tx_go     = 1'b0;
      spi_abort = 1'b0;
      case (state)
         S_LOCKED:  if (brk_vld) state_nxt = S_ARMED;
         S_ARMED: begin
            if (byte_vld) state_nxt = (rx_sh == 8'hBC) ? S_IDLE : S_LOCKED;
         end
         S_IDLE: begin
            if (byte_vld && rx_sh == 8'h01)      state_nxt = S_LEN0;
            else if (byte_vld && rx_sh == 8'h00) state_nxt = S_BOOT;
         end
         S_LEN0:    if (byte_vld) state_nxt = S_LEN1;
         S_LEN1:    if (byte_vld) state_nxt = S_LEN2;
         S_LEN2:    if (byte_vld) state_nxt = S_LEN3;
         S_LEN3: begin
            if (byte_vld) begin
               if (txlen != 16'd0)                state_nxt = S_TX;
               else if ({rx_sh, len_lo} != 16'd0) state_nxt = S_RX_SPI;
               else                               state_nxt = S_IDLE;
            end
         end
         S_TX: begin
            spi_go = byte_vld;
            if (spi_done && txlen == 16'd0) state_nxt = (rxlen != 16'd0) ? S_RX_SPI : S_END;
         end
         S_RX_SPI: begin
            spi_go    = 1'b1;
            spi_byte  = 8'h00;
            state_nxt = S_RX_WAIT;
         end
         S_RX_WAIT: if (spi_done) state_nxt = S_RX_SEND;
         S_RX_SEND: begin
            if (!tx_busy) begin
               tx_go     = 1'b1;
               state_nxt = (rxlen == 16'd0) ? S_END : S_RX_SPI;
            end
         end
         S_END:     if (end_cnt == END_M1) state_nxt = S_IDLE;
         S_BOOT:    state_nxt = S_BOOT;
         default:   state_nxt = S_LOCKED;
      endcase
      if (brk_vld && state inside {S_IDLE, S_LEN0, S_LEN1, S_LEN2, S_LEN3,
                                   S_TX, S_RX_SPI, S_RX_WAIT, S_RX_SEND, S_END}) begin
         state_nxt = S_IDLE;
         spi_abort = 1'b1;
         spi_go    = 1'b0;
         tx_go     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         txlen   <= '0;
         rxlen   <= '0;
         len_lo  <= '0;
         end_cnt <= '0;
      end else begin
         end_cnt <= (state == S_END) ? end_cnt + 1'b1 : '0;
         case (state)
            S_LEN0:   if (byte_vld) len_lo <= rx_sh;
            S_LEN1:   if (byte_vld) txlen  <= {rx_sh, len_lo};
            S_LEN2:   if (byte_vld) len_lo <= rx_sh;
            S_LEN3:   if (byte_vld) rxlen  <= {rx_sh, len_lo};
            S_TX:     if (byte_vld) txlen  <= txlen - 16'd1;
            S_RX_SPI: rxlen <= rxlen - 16'd1;
            default:  ;
         endcase
      end
   end

   assign spi_ss_n = !(state inside {S_TX, S_RX_SPI, S_RX_WAIT, S_RX_SEND});
   assign boot     = (state == S_BOOT);

endmodule

// File: tb/tb_bootloader_top.sv
// Randomised bench for bootloader_top: a byte-stream protocol model feeds MOSI/window/UART expectation queues
// that free-running monitors drain; a flash model serves MISO bytes from a queue.
module tb_bootloader_top;
   localparam int BIT = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic uart0_rx = 1'b1;
   logic spi_si = 1'b0;
   logic uart0_tx, spi_so, spi_sck, spi_ss_n, boot;
   wire  i2c_sda, i2c_scl;

   bootloader_top #(
      .CLK_FREQ(12000000), .UART_BAUDRATE(1000000), .SPI_CLK_DIV(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .uart0_rx(uart0_rx), .uart0_tx(uart0_tx),
      .spi_si(spi_si), .spi_so(spi_so), .spi_sck(spi_sck), .spi_ss_n(spi_ss_n),
      .i2c_sda(i2c_sda), .i2c_scl(i2c_scl), .boot(boot)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err = 0;

   logic [7:0] exp_mosi[$];
   logic [7:0] exp_uart[$];
   logic [7:0] flash_q[$];
   int         exp_win[$];

   // protocol model state
   bit         m_unlocked, m_armed, m_booted;
   logic [7:0] m_hdr[$];
   int         m_left, m_rx, m_sent, m_opened;
   int         n_falls;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic close_window();
      repeat (m_rx) exp_mosi.push_back(8'h00);
      exp_win.push_back(m_sent + m_rx);
   endtask

   task automatic model_byte(input logic [7:0] b);
      int tx, rx;
      logic [7:0] d;
      if (m_booted) return;
      if (!m_unlocked) begin
         if (m_armed) begin
            m_unlocked = (b == 8'hBC);
            m_armed = 1'b0;
         end
         return;
      end
      if (m_left > 0) begin
         exp_mosi.push_back(b);
         m_sent++;
         m_left--;
         if (m_left == 0) close_window();
         return;
      end
      if (m_hdr.size() == 0) begin
         if (b == 8'h01) m_hdr.push_back(b);
         else if (b == 8'h00) m_booted = 1'b1;
         return;
      end
      m_hdr.push_back(b);
      if (m_hdr.size() == 5) begin
         tx = int'(m_hdr[1]) + 256 * int'(m_hdr[2]);
         rx = int'(m_hdr[3]) + 256 * int'(m_hdr[4]);
         m_hdr.delete();
         if (tx + rx > 0) begin
            m_opened++;
            repeat (tx) flash_q.push_back(8'($urandom));
            repeat (rx) begin
               d = 8'($urandom);
               flash_q.push_back(d);
               exp_uart.push_back(d);
            end
            m_rx = rx;
            m_sent = 0;
            m_left = tx;
            if (tx == 0) close_window();
         end
      end
   endtask

   task automatic model_break();
      if (m_booted) return;
      if (!m_unlocked) begin
         m_armed = 1'b1;
         return;
      end
      m_hdr.delete();
      if (m_left > 0) begin
         exp_win.push_back(m_sent);
         flash_q.delete();
         repeat (m_rx) void'(exp_uart.pop_back());
         m_left = 0;
      end
   endtask

   task automatic send(input logic [7:0] b);
      logic [9:0] frame;
      model_byte(b);
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         uart0_rx = frame[i];
         repeat (BIT - 1) @(negedge clk);
      end
   endtask

   task automatic send_break();
      repeat (BIT) @(negedge clk);
      model_break();
      uart0_rx = 1'b0;
      repeat (19 * BIT) @(negedge clk);
      uart0_rx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((exp_mosi.size() != 0 || exp_uart.size() != 0 || exp_win.size() != 0 ||
              !spi_ss_n || n_falls != m_opened) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk("transfer completes in budget", int'(t < 20000), 1);
      chk("flash queue drained", flash_q.size(), 0);
      repeat (2 * BIT) @(negedge clk);
   endtask

   function automatic logic peek_msb();
      return (flash_q.size() != 0) ? flash_q[0][7] : 1'b0;
   endfunction

   // flash model + SPI monitor
   initial begin
      logic p_sck, p_ss;
      logic [7:0] cur, msh;
      int bitn, mbits, wbytes;
      p_sck = 1'b0; p_ss = 1'b1; cur = '0; msh = '0;
      bitn = 0; mbits = 0; wbytes = 0;
      forever begin
         @(negedge clk);
         if (p_ss && !spi_ss_n) begin
            n_falls++;
            chk("ss_n fall expected", int'(n_falls <= m_opened), 1);
            bitn = 0; mbits = 0; wbytes = 0;
            spi_si = peek_msb();
         end
         if (!p_sck && spi_sck) begin
            chk("sck rise inside ss_n window", int'(spi_ss_n), 0);
            if (bitn == 0) cur = (flash_q.size() != 0) ? flash_q.pop_front() : 8'h00;
            bitn = (bitn + 1) % 8;
            msh = {msh[6:0], spi_so};
            mbits++;
            if (mbits == 8) begin
               mbits = 0;
               wbytes++;
               chk("mosi byte expected", int'(exp_mosi.size() != 0), 1);
               if (exp_mosi.size() != 0) chk("mosi byte", int'(msh), int'(exp_mosi.pop_front()));
            end
         end
         if (p_sck && !spi_sck) spi_si = (bitn == 0) ? peek_msb() : cur[7 - bitn];
         if (!p_ss && spi_ss_n) begin
            chk("sck low at ss_n rise", int'(spi_sck), 0);
            chk("no partial spi byte", mbits, 0);
            chk("window length expected", int'(exp_win.size() != 0), 1);
            if (exp_win.size() != 0) chk("window byte count", wbytes, exp_win.pop_front());
         end
         p_sck = spi_sck;
         p_ss = spi_ss_n;
      end
   end

   // UART TX monitor
   initial begin
      logic [7:0] d;
      forever begin
         @(negedge clk);
         if (rst_n && !uart0_tx) begin
            repeat (BIT / 2) @(negedge clk);
            chk("uart start bit", int'(uart0_tx), 0);
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) @(negedge clk);
               d[i] = uart0_tx;
            end
            repeat (BIT) @(negedge clk);
            chk("uart stop bit", int'(uart0_tx), 1);
            chk("uart byte expected", int'(exp_uart.size() != 0), 1);
            if (exp_uart.size() != 0) chk("uart byte", int'(d), int'(exp_uart.pop_front()));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int tx, rx;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset uart0_tx", int'(uart0_tx), 1);
      chk("reset spi_ss_n", int'(spi_ss_n), 1);
      chk("reset spi_sck", int'(spi_sck), 0);
      chk("reset spi_so", int'(spi_so), 0);
      chk("reset boot", int'(boot), 0);
      rst_n = 1'b1;
      repeat (3 * BIT) @(negedge clk);

      // unlock byte without a break is ignored
      send(8'hBC); send(8'h01);
      wait_idle();
      chk("locked: ss_n idle", int'(spi_ss_n), 1);

      send_break(); send(8'hBC);
      send(8'h01); send(8'h02); send(8'h00); send(8'h05); send(8'h00); send(8'h9F); send(8'h00);
      wait_idle();

      send(8'h01); send(8'h02); send(8'h00);
      send_break();
      send(8'h01); send(8'h02); send(8'h00); send(8'h05); send(8'h00); send(8'h9F); send(8'h00);
      wait_idle();

      send(8'h01); send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h06);
      send(8'h01); send(8'h04); send(8'h00); send(8'h00); send(8'h00);
      send(8'hD8); send(8'h02); send(8'h00); send(8'h00);
      wait_idle();

      send(8'h01); send(8'h00); send(8'h00); send(8'h01); send(8'h00);
      wait_idle();

      // zero-length command never touches ss_n
      send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
      wait_idle();

      // break in the middle of the write phase
      send(8'h01); send(8'h03); send(8'h00); send(8'h02); send(8'h00); send(8'hAA);
      send_break();
      wait_idle();

      for (int k = 0; k < 6; k++) begin
         send(8'($urandom_range(2, 255)));
         tx = $urandom_range(0, 3);
         rx = $urandom_range(0, 3);
         send(8'h01); send(8'(tx)); send(8'h00); send(8'(rx)); send(8'h00);
         repeat (tx) send(8'($urandom));
         wait_idle();
      end

      chk("boot low before boot command", int'(boot), 0);
      send(8'h00);
      repeat (4) @(negedge clk);
      chk("boot asserted", int'(boot), int'(m_booted));
      send(8'h01); send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h11);
      send_break();
      send(8'h01);
      wait_idle();
      chk("boot sticky", int'(boot), 1);
      chk("ss_n idle in boot", int'(spi_ss_n), 1);

      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("reset clears boot", int'(boot), 0);
      chk("reset ss_n", int'(spi_ss_n), 1);
      rst_n = 1'b1;
      m_booted = 1'b0; m_unlocked = 1'b0; m_armed = 1'b0; m_hdr.delete();
      repeat (3 * BIT) @(negedge clk);

      send_break(); send(8'hBC);
      send(8'h01); send(8'h01); send(8'h00); send(8'h02); send(8'h00); send(8'h5A);
      wait_idle();

      chk("leftover mosi expectations", exp_mosi.size(), 0);
      chk("leftover uart expectations", exp_uart.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
